pwm_multi_channel: RTL and testbench
====================================

Name: pwm_multi_channel

Overview:
Parametrised successor to the fixed 4-channel/8-bit PWM block. NUM_CH channels share one prescaled timebase with a programmable period, in edge-aligned or center-aligned mode. Duty, period, mode, polarity and enables are double-buffered: they load only at a period boundary, on handshake, so outputs never glitch. Sits between the register/control layer and the pad/driver logic.

Parameters:
NUM_CH, 4, number of PWM channels (1..16)
CNT_W, 8, width of counter, period and duty values
PRESC_W, 8, width of prescaler divide value

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
enable  input  1  timebase run; low = counter/prescaler held at 0, outputs at idle level
prescale  input  PRESC_W  tick every prescale+1 clocks
period  input  CNT_W  shadow period value P
center_mode  input  1  shadow mode: 0 edge-aligned, 1 center-aligned
duty_flat  input  NUM_CH*CNT_W  shadow duty D per channel; ch i at [i*CNT_W +: CNT_W]
polarity  input  NUM_CH  shadow polarity; 1 = active-low output
ch_en  input  NUM_CH  shadow channel enable
update_req  input  1  one-clock pulse: load shadow values at next boundary
update_ack  output  1  one-clock pulse when shadow values were loaded
period_start  output  1  one-clock pulse when counter restarts at 0
pwm_out  output  NUM_CH  PWM outputs (registered)

Behaviour:
- Reset: cnt=0, prescaler=0, direction=up, active regs (P, D, mode, polarity, ch_en) = 0, pending=0, pwm_out=0, update_ack=0, period_start=0.
- prescale is live (not shadowed). tick = prescaler==prescale; prescaler then wraps to 0. prescale=0 -> tick every clock.
- Edge mode: cnt counts 0..P on ticks, then 0; period = (P+1) ticks. raw_i = cnt < D_i; D_i > P -> 100%, D_i=0 -> 0%.
- Center mode: cnt counts up 0..P, then down P-1..1, then 0; period = 2P ticks. Up phase raw_i = cnt < D_i; down phase raw_i = cnt <= D_i; D_i >= P -> forced high. High ticks = 2*D_i for D_i<P. P=0 in center mode: cnt stays 0, boundary every tick.
- Boundary = tick while cnt at last position (edge: cnt==P; center: down phase with cnt==1, or P=0). At boundary cnt<=0, direction<=up.
- period_start pulses the clock after cnt is loaded with 0 on a tick (and the clock after enable rises).
- pwm_out[i] <= ch_en_i ? (raw_i ^ polarity_i) : polarity_i; one clock latency from cnt. Disabled or enable=0 -> idle level polarity_i.
- update_req sets pending. At boundary with pending (or update_req asserted in that same cycle): all shadow inputs sampled into active regs, pending cleared, update_ack pulses next clock. Shadow inputs must be stable from update_req until update_ack.
- update_req while pending: no effect (single load).
- enable 0->1: immediate load of shadow values (treated as boundary), pending cleared, update_ack pulses, cnt starts at 0.
- enable 1->0: cnt/prescaler/direction cleared next clock; pending retained; active regs retained.
- Active P reduced below current cnt can only occur at a boundary, so no overshoot case exists.
- Async rst mid-period: all state to reset values immediately; no pulse on ack/period_start.

Decomposition:
- Package pwm_pkg: mode enum (PWM_EDGE, PWM_CENTER), default width constants, helper function extracting channel duty from flat bus.
- Sub-module pwm_timebase: prescaler, up/down counter, direction, tick/boundary/period_start generation. Per-channel compare/polarity logic is a generate loop in the top.

Test Plan:
- Edge, prescale=0, P=9, D0=3, D1=0, D2=10, D3=9, all enabled -> period 10 clocks; ch0 high 3, ch1 always 0, ch2 always 1, ch3 high 9.
- Center, P=4, D0=1, D1=3, D2=4 -> period 8 clocks; ch0 high 2 symmetric around cnt=0, ch1 high 6, ch2 always 1.
- Edge P=9 D0=3 running; mid-period set D0=7 and pulse update_req -> current period keeps 3 high; update_ack at boundary; next period 7 high.
- polarity=4'b0101, ch_en=4'b0011, D=2, P=3 -> ch0 active-low (low 2 of 4), ch1 active-high, ch2 idle 1, ch3 idle 0.
- prescale=2, P=3, D0=1 -> ch0 high 3 clocks, period 12 clocks; period_start every 12 clocks.
- Assert rst at cnt=5 of P=9 -> pwm_out=0, update_ack=0 immediately; after release and enable rise, load from shadow and clean restart at cnt=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types, default widths and a duty-extraction helper for the multi-channel PWM.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PRESC_W = 8;
  localparam int MAX_CH      = 16;
  localparam int MAX_W       = 32;

  // Callers zero-pad the flat duty bus to MAX_CH*MAX_W so one helper serves any width.
  function automatic logic [MAX_W-1:0] duty_of(input logic [MAX_CH*MAX_W-1:0] flat,
                                               input int w, input int ch);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_W; b++) begin
      if (b < w) r[b] = flat[ch*w + b];
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaler and edge/center-aligned counter; flags the period boundary and restart.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [CNT_W-1:0]   period_a,
  input  pwm_mode_e          mode_a,
  output logic [CNT_W-1:0]   cnt,
  output logic               count_down,
  output logic               run,
  output logic               restart,
  output logic               boundary,
  output logic               period_start
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               en_q;
  logic               ps_q, ps_d;
  logic               tick, last;

  assign restart = enable & ~en_q;
  assign run     = enable & en_q;
  assign tick    = run && (presc_q == prescale);

  // Center mode with P<=1 has no down phase, so its last position is the top of the ramp.
  always_comb begin
    if (mode_a == PWM_EDGE || period_a <= CNT_W'(1)) last = (cnt_q == period_a);
    else                                           last = dir_q && (cnt_q == CNT_W'(1));
  end

  assign boundary = tick & last;

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ps_d    = 1'b0;
    if (!enable || restart) begin
      presc_d = '0;
      cnt_d   = '0;
      dir_d   = 1'b0;
      ps_d    = restart;
    end else if (tick) begin
      presc_d = '0;
      if (last) begin
        cnt_d = '0;
        dir_d = 1'b0;
        ps_d  = 1'b1;
      end else if (dir_q) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (mode_a == PWM_CENTER && cnt_q == period_a) begin
        dir_d = 1'b1;
        cnt_d = period_a - CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      en_q    <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      en_q    <= enable;
      ps_q    <= ps_d;
    end
  end

  assign cnt          = cnt_q;
  assign count_down   = dir_q;
  assign period_start = ps_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// NUM_CH PWM channels on one timebase; configuration is double-buffered and loads at period boundaries.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PRESC_W-1:0]      prescale,
  input  logic [CNT_W-1:0]        period,
  input  logic                    center_mode,
  input  logic [NUM_CH*CNT_W-1:0] duty_flat,
  input  logic [NUM_CH-1:0]       polarity,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    update_req,
  output logic                    update_ack,
  output logic                    period_start,
  output logic [NUM_CH-1:0]       pwm_out
);

  logic [CNT_W-1:0]        period_q, period_d;
  pwm_mode_e               mode_q, mode_d;
  logic [NUM_CH*CNT_W-1:0] duty_q, duty_d;
  logic [NUM_CH-1:0]       pol_q, pol_d, chen_q, chen_d, pwm_q, pwm_d, raw_vec;
  logic                    pending_q, pending_d, ack_q, ack_d, load;
  logic [CNT_W-1:0]        cnt;
  logic                    count_down, run, restart, boundary;

  pwm_timebase #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_timebase (
    .clk(clk), .rst(rst), .enable(enable), .prescale(prescale),
    .period_a(period_q), .mode_a(mode_q), .cnt(cnt), .count_down(count_down),
    .run(run), .restart(restart), .boundary(boundary), .period_start(period_start)
  );

  assign load = restart | (boundary & (pending_q | update_req));

  always_comb begin
    period_d  = period_q;
    mode_d    = mode_q;
    duty_d    = duty_q;
    pol_d     = pol_q;
    chen_d    = chen_q;
    pending_d = pending_q | update_req;
    ack_d     = load;
    if (load) begin
      period_d  = period;
      mode_d    = pwm_mode_e'(center_mode);
      duty_d    = duty_flat;
      pol_d     = polarity;
      chen_d    = ch_en;
      pending_d = 1'b0;
    end
  end

  logic [MAX_CH*MAX_W-1:0] flat_pad;
  logic [MAX_W-1:0]        cnt_pad, period_pad;

  always_comb begin
    flat_pad                     = '0;
    flat_pad[NUM_CH*CNT_W-1:0]   = duty_q;
    cnt_pad                      = '0;
    cnt_pad[CNT_W-1:0]           = cnt;
    period_pad                   = '0;
    period_pad[CNT_W-1:0]        = period_q;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [MAX_W-1:0] duty_w;
    assign duty_w = duty_of(flat_pad, CNT_W, i);
    // Down phase compares with <= so the high window is symmetric around cnt==0.
    assign raw_vec[i] = (mode_q == PWM_CENTER)
                        ? ((duty_w >= period_pad) ||
                           (count_down ? (cnt_pad <= duty_w) : (cnt_pad < duty_w)))
                        : (cnt_pad < duty_w);
  end

  always_comb pwm_d = pol_q ^ (raw_vec & chen_q & {NUM_CH{run}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q  <= '0;
      mode_q    <= PWM_EDGE;
      duty_q    <= '0;
      pol_q     <= '0;
      chen_q    <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      pwm_q     <= '0;
    end else begin
      period_q  <= period_d;
      mode_q    <= mode_d;
      duty_q    <= duty_d;
      pol_q     <= pol_d;
      chen_q    <= chen_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      pwm_q     <= pwm_d;
    end
  end

  assign update_ack = ack_q;
  assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench: per-period length and per-channel high counts from the spec, compared against measured windows.
module tb_pwm_multi_channel;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 8;

  logic                    clk = 1'b0;
  logic                    rst, enable, center_mode, update_req;
  logic [PRESC_W-1:0]      prescale;
  logic [CNT_W-1:0]        period;
  logic [NUM_CH*CNT_W-1:0] duty_flat;
  logic [NUM_CH-1:0]       polarity, ch_en, pwm_out, act_pol;
  logic                    update_ack, period_start;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .prescale(prescale), .period(period),
    .center_mode(center_mode), .duty_flat(duty_flat), .polarity(polarity), .ch_en(ch_en),
    .update_req(update_req), .update_ack(update_ack), .period_start(period_start),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int len, input int h0, input int h1, input int h2, input int h3);
    exp_q.push_back(len);
    exp_q.push_back(h0);
    exp_q.push_back(h1);
    exp_q.push_back(h2);
    exp_q.push_back(h3);
  endtask

  task automatic config_shadow(input logic [PRESC_W-1:0] ps, input logic [CNT_W-1:0] p,
                               input logic cm, input logic [NUM_CH*CNT_W-1:0] d,
                               input logic [NUM_CH-1:0] pol, input logic [NUM_CH-1:0] en);
    prescale = ps; period = p; center_mode = cm; duty_flat = d; polarity = pol; ch_en = en;
  endtask

  task automatic start(input string name);
    enable = 1'b1;
    @(negedge clk);
    check({name, ".rise_ack"}, 32'(update_ack), 1);
    check({name, ".rise_ps"}, 32'(period_start), 1);
    act_pol = polarity;
  endtask

  task automatic stop(input string name);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check({name, ".idle"}, 32'(pwm_out), 32'(act_pol));
    check({name, ".idle_ps"}, 32'(period_start), 0);
  endtask

  task automatic wait_ps(output bit got);
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (period_start) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Window runs from the sample after one period_start through the next one: exactly one period of pwm_out.
  task automatic measure(input string name, input int req_at, input logic [NUM_CH*CNT_W-1:0] new_duty,
                         output logic [NUM_CH-1:0] first, output logic [NUM_CH-1:0] last,
                         output int acks, output logic last_ack);
    bit got;
    bit done;
    int len;
    int hi[NUM_CH];
    first = '0; last = '0; acks = 0; last_ack = 1'b0; len = 0; done = 1'b0;
    for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
    wait_ps(got);
    if (got) begin
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        len++;
        for (int c = 0; c < NUM_CH; c++) hi[c] += int'(pwm_out[c]);
        if (len == 1) first = pwm_out;
        last = pwm_out;
        acks += int'(update_ack);
        last_ack = update_ack;
        if (len - 1 == req_at) begin
          duty_flat  = new_duty;
          update_req = 1'b1;
        end else begin
          update_req = 1'b0;
        end
        if (period_start) begin
          done = 1'b1;
          break;
        end
      end
    end
    update_req = 1'b0;
    if (!done) begin
      check({name, ".timeout"}, 0, 1);
      repeat (5) void'(exp_q.pop_front());
    end else begin
      check({name, ".len"}, len, exp_q.pop_front());
      for (int c = 0; c < NUM_CH; c++)
        check($sformatf("%s.high%0d", name, c), hi[c], exp_q.pop_front());
    end
  endtask

  logic [NUM_CH-1:0] f, l;
  int                acks;
  logic              lack;

  initial begin
    rst = 1'b1; enable = 1'b0; update_req = 1'b0; act_pol = '0;
    config_shadow(0, 0, 0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst.pwm", 32'(pwm_out), 0);
    check("rst.ack", 32'(update_ack), 0);
    check("rst.ps", 32'(period_start), 0);
    rst = 1'b0;
    @(negedge clk);

    // Edge P=9: ch0 D=3, ch1 D=0, ch2 D=10 (>P), ch3 D=9
    config_shadow(0, 9, 0, {8'd9, 8'd10, 8'd0, 8'd3}, 4'b0000, 4'b1111);
    start("t1");
    push_exp(10, 3, 0, 10, 9);
    measure("t1", -1, '0, f, l, acks, lack);
    check("t1.first0", 32'(f[0]), 1);
    check("t1.last0", 32'(l[0]), 0);

    // Mid-period duty change: current period keeps D0=3, load at boundary, then D0=7
    push_exp(10, 3, 0, 10, 9);
    measure("t3a", 2, {8'd9, 8'd10, 8'd0, 8'd7}, f, l, acks, lack);
    check("t3a.acks", acks, 1);
    check("t3a.ack_at_boundary", 32'(lack), 1);
    push_exp(10, 7, 0, 10, 9);
    measure("t3b", -1, '0, f, l, acks, lack);
    check("t3b.acks", acks, 0);
    stop("t3");

    // Center P=4: ch0 D=1, ch1 D=3, ch2 D=4 (forced high), ch3 D=0
    config_shadow(0, 4, 1, {8'd0, 8'd4, 8'd3, 8'd1}, 4'b0000, 4'b1111);
    start("t2");
    push_exp(8, 2, 6, 8, 0);
    measure("t2", -1, '0, f, l, acks, lack);
    check("t2.first0", 32'(f[0]), 1);
    check("t2.last0", 32'(l[0]), 1);
    stop("t2");

    // Polarity/enable mix, edge P=3, D=2
    config_shadow(0, 3, 0, {4{8'd2}}, 4'b0101, 4'b0011);
    start("t4");
    push_exp(4, 2, 2, 4, 0);
    measure("t4", -1, '0, f, l, acks, lack);
    check("t4.first", 32'(f), 32'(4'b0110));
    stop("t4");

    // Prescale=2, P=3, D=1: 12-clock period, 3 clocks high
    config_shadow(2, 3, 0, {4{8'd1}}, 4'b0000, 4'b1111);
    start("t5");
    push_exp(12, 3, 3, 3, 3);
    measure("t5", -1, '0, f, l, acks, lack);
    stop("t5");

    // Async reset mid-period with an update pending, then clean restart from shadow
    config_shadow(0, 9, 0, {8'd9, 8'd10, 8'd0, 8'd3}, 4'b0000, 4'b1111);
    start("t6");
    wait_ps(f[0]);
    check("t6.ps_seen", 32'(f[0]), 1);
    repeat (5) @(negedge clk);
    check("t6.pre_ch2", 32'(pwm_out[2]), 1);
    duty_flat  = {8'd9, 8'd10, 8'd0, 8'd5};
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6.rst_pwm", 32'(pwm_out), 0);
    check("t6.rst_ack", 32'(update_ack), 0);
    check("t6.rst_ps", 32'(period_start), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6.rise_ack", 32'(update_ack), 1);
    check("t6.rise_ps", 32'(period_start), 1);
    push_exp(10, 5, 0, 10, 9);
    measure("t6", -1, '0, f, l, acks, lack);
    check("t6.acks", acks, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
